dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 128x8 data memory between NUM_REQ requesters, e.g. the core load/store sequencer, the MOV engine and a debug/preload port.
- Round-robin arbitration with a per-requester bounded lock for back-to-back bursts.
- Drives the data memory strobes (line number, write data, read, write) directly, one transaction at a time.
- Returns read data through a registered response with a requester ID.

Parameters:
- NUM_REQ, 3, number of requesters (2..4)
- ADDR_W, 7, data memory line-number width
- DATA_W, 8, data width
- MAX_HOLD, 4, maximum consecutive grants to one locked requester

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  transaction request, one bit per requester
- we  in  NUM_REQ  1 = write, 0 = read, per requester
- lock  in  NUM_REQ  request back-to-back ownership, per requester
- addr  in  NUM_REQ*ADDR_W  packed line numbers; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot one-cycle grant pulse
- rvalid  out  1  read response valid, one-cycle pulse
- rid  out  2  requester index of the response
- rdata  out  DATA_W  read data, registered
- busy  out  1  high in any state other than IDLE
- mem_line  out  ADDR_W  data memory line number
- mem_in  out  DATA_W  data memory write data
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- mem_out  in  DATA_W  data memory read data, valid the cycle after a mem_read edge

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, hold count 0, locked owner cleared.
  - Reset during ISSUE/WAIT/RESP aborts the transaction: strobes drop next cycle, no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req is sampled here only.
  - If a locked owner exists, its req is high and hold count < MAX_HOLD, it wins.
  - Otherwise the winner is the first set req bit scanning from the pointer upward, with wrap.
  - The winner's addr, we and wdata are registered. Go to ISSUE. No req: stay.
- ISSUE (1 cycle):
  - mem_line and mem_in driven from the registered values; exactly one of mem_write/mem_read high.
  - gnt[winner] = 1.
  - Write: next state IDLE. Read: next state WAIT.
- WAIT (1 cycle): memory output settles; rdata register loads mem_out at the end of this cycle.
- RESP (1 cycle): rvalid = 1, rid = winner, rdata held until the next read response. Next state IDLE.
- Latency from req sampled in IDLE:
  - write: strobe at +1 cycle, busy clears at +2
  - read: rvalid at +3 cycles
- Throughput: one write per 2 cycles, one read per 4 cycles.
- Requester contract:
  - addr, we and wdata are held stable while req is high until gnt.
  - Requesters drop req on the edge ending the gnt cycle unless issuing a new transaction.
- Pointer update: at the end of ISSUE, pointer = winner + 1 mod NUM_REQ. Locked re-grants also update it.
- Lock:
  - If lock[winner] is high in ISSUE, the winner becomes the locked owner and the hold count increments.
  - Otherwise the owner is cleared and the count reset to 0.
  - At hold count = MAX_HOLD, the owner is cleared: the next arbitration is plain round-robin, so other requesters cannot starve.
- mem_line and mem_in are 0 outside ISSUE. Strobes are never high in the same cycle.

Optional Feature:
- Macro: DMEM_ARB_PRIORITY_EN.
- Defined: requester 0 has fixed highest priority, overriding the pointer and any lock held by another requester. Requesters 1..NUM_REQ-1 remain round-robin among themselves. Requester 0's own lock is still bounded by MAX_HOLD.
- Undefined: pure round-robin plus lock as above.

Test Plan:
- Single write: req[1]=1, we[1]=1, addr 0x05, wdata 0xA5 → gnt[1] and mem_write for exactly one cycle with mem_line=0x05, mem_in=0xA5; busy low 2 cycles after req.
- Read after write: read line 0x05 from requester 2 → mem_read one cycle, rvalid 3 cycles after req, rid=2, rdata=0xA5.
- Contention: req=3'b111 held continuously, no lock → grant order 0,1,2,0,1,2; no requester granted twice in a row.
- Lock bound: MAX_HOLD=4, requester 1 with lock=1 and req=1, requester 0 also requesting → requester 1 granted 4 times consecutively, then requester 0 granted.
- Reset mid-read: reset asserted in the WAIT cycle → no rvalid; next cycle all strobes 0, busy 0; a following request from requester 0 wins (pointer 0).
- With DMEM_ARB_PRIORITY_EN: requesters 0 and 2 request every cycle → requester 0 granted every arbitration. Without the macro → alternating 0,2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port 128x8 data memory between NUM_REQ requesters
//   (core load/store sequencer, MOV engine, debug/preload port).
//   Round-robin arbitration with a bounded per-requester lock. Drives the
//   memory strobes directly, one transaction at a time, and returns read
//   data through a registered response tagged with the requester index.
//
//   Optional build macro: DMEM_ARB_PRIORITY_EN
//     defined   -> requester 0 has fixed top priority; 1..NUM_REQ-1 stay
//                  round-robin among themselves; requester 0's own lock is
//                  still bounded by MAX_HOLD.
//     undefined -> pure round-robin plus bounded lock.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   req        in   [NUM_REQ]        transaction request per requester
//   we         in   [NUM_REQ]        1 = write, 0 = read
//   lock       in   [NUM_REQ]        request back-to-back ownership
//   addr       in   [NUM_REQ*ADDR_W] packed line numbers
//   wdata      in   [NUM_REQ*DATA_W] packed write data
//   gnt        out  [NUM_REQ]        one-hot, one-cycle grant pulse
//   rvalid     out  read response valid (one cycle)
//   rid        out  [2]              requester index of the response
//   rdata      out  [DATA_W]         registered read data
//   busy       out  high whenever the FSM is not IDLE
//   mem_line   out  [ADDR_W]         memory line number (0 outside ISSUE)
//   mem_in     out  [DATA_W]         memory write data (0 outside ISSUE)
//   mem_read   out  memory read strobe
//   mem_write  out  memory write strobe
//   mem_out    in   [DATA_W]         memory read data, valid cycle after mem_read

module dmem_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          we,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rvalid,
    output logic [1:0]                  rid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_line,
    output logic [DATA_W-1:0]           mem_in,
    output logic                        mem_read,
    output logic                        mem_write,
    input  logic [DATA_W-1:0]           mem_out
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_next;

    // Registered transaction of the current winner
    logic [1:0]         win;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_we;

    // Arbitration state
    logic [1:0]         ptr;
    logic               own_valid;
    logic [1:0]         own_idx;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   next_cnt;

    // Arbitration results (combinational, used in IDLE only)
    logic               arb_any;
    logic [1:0]         arb_idx;
    logic               lock_win;
    logic               rr_found;
    logic [1:0]         rr_idx;
    logic [NUM_REQ-1:0] rr_req;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_we;

`ifdef DMEM_ARB_PRIORITY_EN
    // Set when requester 0 just used up its lock bound; for one arbitration
    // it then yields to any other pending requester.
    logic               prio_yield;
    logic               p0_win;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned pos;
        rr_req = req;
`ifdef DMEM_ARB_PRIORITY_EN
        rr_req[0] = 1'b0;
`endif
        rr_found = 1'b0;
        rr_idx   = '0;
        pos      = 0;
        // First set bit scanning upward from the pointer, with wrap
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!rr_found && rr_req[pos]) begin
                rr_found = 1'b1;
                rr_idx   = 2'(pos);
            end
        end
    end

    always_comb begin
        arb_any  = |req;
        lock_win = own_valid && req[own_idx] && (hold_cnt < CNT_W'(MAX_HOLD));
        arb_idx  = rr_idx;
`ifdef DMEM_ARB_PRIORITY_EN
        p0_win = req[0] && !(prio_yield && (|req[NUM_REQ-1:1]));
        if (p0_win)
            arb_idx = '0;
        else if (lock_win && own_idx != 2'd0)
            arb_idx = own_idx;
        else if (rr_found)
            arb_idx = rr_idx;
        else
            arb_idx = '0;
`else
        if (lock_win)
            arb_idx = own_idx;
`endif
    end

    // Mux the winner's request fields
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == 2'(i)) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                sel_we    = we[i];
            end
        end
    end

    // Consecutive-grant count if the current winner keeps the lock
    always_comb begin
        if (own_valid && own_idx == win)
            next_cnt = hold_cnt + 1'b1;
        else
            next_cnt = CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_any) state_next = ISSUE;
            ISSUE:   state_next = win_we ? IDLE : WAIT;
            WAIT:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        gnt       = '0;
        mem_line  = '0;
        mem_in    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rvalid    = 1'b0;
        rid       = '0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                for (int unsigned i = 0; i < NUM_REQ; i++)
                    gnt[i] = (win == 2'(i));
                mem_line  = win_addr;
                mem_in    = win_wdata;
                mem_write = win_we;
                mem_read  = !win_we;
            end
            RESP: begin
                rvalid = 1'b1;
                rid    = win;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and arbitration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            win        <= '0;
            win_addr   <= '0;
            win_wdata  <= '0;
            win_we     <= 1'b0;
            ptr        <= '0;
            own_valid  <= 1'b0;
            own_idx    <= '0;
            hold_cnt   <= '0;
            rdata      <= '0;
`ifdef DMEM_ARB_PRIORITY_EN
            prio_yield <= 1'b0;
`endif
        end else begin
            if (state == IDLE && arb_any) begin
                win       <= arb_idx;
                win_addr  <= sel_addr;
                win_wdata <= sel_wdata;
                win_we    <= sel_we;
            end

            if (state == ISSUE) begin
                ptr <= (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
`ifdef DMEM_ARB_PRIORITY_EN
                prio_yield <= 1'b0;
`endif
                if (lock[win]) begin
                    // Reaching the bound releases ownership so the next
                    // arbitration is plain round-robin.
                    if (next_cnt >= CNT_W'(MAX_HOLD)) begin
                        own_valid <= 1'b0;
                        hold_cnt  <= '0;
`ifdef DMEM_ARB_PRIORITY_EN
                        prio_yield <= (win == 2'd0);
`endif
                    end else begin
                        own_valid <= 1'b1;
                        own_idx   <= win;
                        hold_cnt  <= next_cnt;
                    end
                end else begin
                    own_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            end

            if (state == WAIT)
                rdata <= mem_out;
        end
    end

endmodule
